// File: rtl/toa_pkg.sv
// ---------------------------------------------------------------------------
// toa_pkg
// Shared constants and types for the TOA fine delay-line code generator.
//   N_TAPS   : delay-line length (odd)
//   POS_W    : width of the edge-position field
//   NO_EDGE  : position value meaning "no edge in the line"
//   LVL_*    : bubble injection levels
//   state_e  : generator FSM states
// ---------------------------------------------------------------------------
package toa_pkg;

    localparam int          N_TAPS    = 63;
    localparam int          POS_W     = 6;
    localparam logic [5:0]  NO_EDGE   = 6'd63;

    localparam logic [2:0]  LVL_IDEAL = 3'd1;
    localparam logic [2:0]  LVL_BUB1  = 3'd2;
    localparam logic [2:0]  LVL_BUB2  = 3'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage : toa_pkg

// File: rtl/toa_fine_code_map.sv
// ---------------------------------------------------------------------------
// toa_fine_code_map
// Purely combinational map from a 7-bit fine value to a 63-tap ring code.
// Ports:
//   value [6:0] : [6] polarity, [5:0] edge position P (63 = no edge)
//   level [2:0] : bubble level; 2 and 3 inject bubbles, anything else = ideal
//   word  [62:0]: delay-line word
// ---------------------------------------------------------------------------
module toa_fine_code_map
    import toa_pkg::*;
(
    input  logic [6:0]        value,
    input  logic [2:0]        level,
    output logic [N_TAPS-1:0] word
);

    logic             pol;
    logic [POS_W-1:0] pos;
    int               d;

    assign pol = value[6];
    assign pos = value[POS_W-1:0];

    always_comb begin
        word = '0;
        d    = 0;
        if (pos == NO_EDGE) begin
            word = {N_TAPS{pol}};
        end else begin
            for (int i = 0; i < N_TAPS; i++) begin
                // Distance of tap i from the edge, taken around the ring.
                d = i - int'(pos);
                if (d < 0) begin
                    d = d + N_TAPS;
                end
                word[i] = d[0] ^ pol;
                // Bubbles: one just past the edge, and one near the far end.
                if (((level == LVL_BUB1) || (level == LVL_BUB2)) && (d == 2)) begin
                    word[i] = ~word[i];
                end
                if ((level == LVL_BUB2) && (d == N_TAPS - 3)) begin
                    word[i] = ~word[i];
                end
            end
        end
    end

endmodule : toa_fine_code_map

// File: rtl/toa_fine_code_gen.sv
// ---------------------------------------------------------------------------
// toa_fine_code_gen
// Sequential generator of TOA fine delay-line codes, single-shot or sweep.
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   start        : request pulse, accepted only while busy = 0
//   mode         : 0 = single code, 1 = sweep of sweep_len codes
//   level        : bubble level 1..3 (others act as 1), sampled at start
//   value_in     : [6] polarity, [5:0] edge position (63 = no edge)
//   sweep_len    : number of codes in a sweep (0 acts as 1)
//   busy         : high from accepted start until the last code is issued
//   code_valid   : one-cycle qualifier per output code
//   code_out     : generated delay-line word (held when code_valid = 0)
//   value_out    : expected encoder result paired with code_out
//   done         : pulses together with the last code_valid
// ---------------------------------------------------------------------------
module toa_fine_code_gen
    import toa_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [2:0]        level,
    input  logic [6:0]        value_in,
    input  logic [6:0]        sweep_len,
    output logic              busy,
    output logic              code_valid,
    output logic [N_TAPS-1:0] code_out,
    output logic [6:0]        value_out,
    output logic              done
);

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [6:0]        cur_val_q, cur_val_d;
    logic [2:0]        lvl_q, lvl_d;

    logic              vld_p1_q, vld_p1_d;
    logic              last_p1_q, last_p1_d;
    logic [6:0]        val_p1_q, val_p1_d;
    logic [2:0]        lvl_p1_q, lvl_p1_d;

    logic              vld_p2_q, vld_p2_d;
    logic              done_p2_q, done_p2_d;
    logic [N_TAPS-1:0] code_p2_q, code_p2_d;
    logic [6:0]        val_p2_q, val_p2_d;

    logic [N_TAPS-1:0] map_word;

    function automatic logic [2:0] clamp_level(input logic [2:0] l);
        case (l)
            LVL_BUB1, LVL_BUB2: clamp_level = l;
            default:            clamp_level = LVL_IDEAL;
        endcase
    endfunction

    function automatic logic [6:0] clamp_len(input logic [6:0] n);
        clamp_len = (n == 7'd0) ? 7'd1 : n;
    endfunction

    // Step one tap around the ring; leaving the last tap (or the no-edge
    // value) wraps to tap 0 with the polarity flipped.
    function automatic logic [6:0] next_value(input logic [6:0] v);
        if (v[POS_W-1:0] >= (NO_EDGE - 6'd1)) begin
            next_value = {~v[6], 6'd0};
        end else begin
            next_value = v + 7'd1;
        end
    endfunction

    toa_fine_code_map u_map (
        .value (val_p1_q),
        .level (lvl_p1_q),
        .word  (map_word)
    );

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        cur_val_d = cur_val_q;
        lvl_d     = lvl_q;
        vld_p1_d  = 1'b0;
        last_p1_d = 1'b0;
        val_p1_d  = val_p1_q;
        lvl_p1_d  = lvl_p1_q;

        // ---- stage 1 -> stage 2: map the registered value to a code ----
        vld_p2_d  = vld_p1_q;
        done_p2_d = vld_p1_q & last_p1_q;
        code_p2_d = code_p2_q;
        val_p2_d  = val_p2_q;
        if (vld_p1_q) begin
            code_p2_d = map_word;
            val_p2_d  = val_p1_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    busy_d    = 1'b1;
                    cur_val_d = value_in;
                    lvl_d     = clamp_level(level);
                    cnt_d     = mode ? clamp_len(sweep_len) : 7'd1;
                end
            end
            RUN: begin
                // ---- issue -> stage 1 ----
                vld_p1_d = 1'b1;
                val_p1_d = cur_val_q;
                lvl_p1_d = lvl_q;
                cnt_d    = cnt_q - 7'd1;
                if (cnt_q == 7'd1) begin
                    last_p1_d = 1'b1;
                    state_d   = DRAIN;
                end else begin
                    cur_val_d = next_value(cur_val_q);
                end
            end
            DRAIN: begin
                // busy drops on the same edge that presents the last code.
                if (vld_p1_q && last_p1_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= 7'd0;
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
            vld_p2_q  <= 1'b0;
            done_p2_q <= 1'b0;
            code_p2_q <= '0;
            val_p2_q  <= 7'd0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            vld_p1_q  <= vld_p1_d;
            last_p1_q <= last_p1_d;
            vld_p2_q  <= vld_p2_d;
            done_p2_q <= done_p2_d;
            code_p2_q <= code_p2_d;
            val_p2_q  <= val_p2_d;
        end
    end

    // Working value and stage-1 data are always qualified by control flops,
    // so they need no reset.
    always_ff @(posedge clk) begin
        cur_val_q <= cur_val_d;
        lvl_q     <= lvl_d;
        val_p1_q  <= val_p1_d;
        lvl_p1_q  <= lvl_p1_d;
    end

    assign busy       = busy_q;
    assign code_valid = vld_p2_q;
    assign done       = done_p2_q;
    assign code_out   = code_p2_q;
    assign value_out  = val_p2_q;

endmodule : toa_fine_code_gen

// File: doc/toa_fine_code_gen.md
Name: toa_fine_code_gen

Overview:
- Sequential generator of 63-tap TOA fine delay-line codes. It maps a 7-bit binary fine value to a 63-bit ring code, which is the inverse of the TOA fine encoder.
- Used as an on-chip/FPGA stimulus source and loopback checker feed. It drives the fine encoder input and emits the expected binary value alongside each code.
- Supports two modes: single-shot conversion, and auto-increment sweep over the ring.

Parameters:
- N_TAPS, 63, delay-line length; must be odd; position field is 6 bits.
- PIPE, 2, output latency in cycles from accepted request/sweep step to code_valid; fixed at 2.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  request pulse; accepted only when busy=0
- mode  in  1  0 = single, 1 = sweep
- level  in  3  bubble injection level, 1..3; values 0 and 4..7 are treated as 1
- value_in  in  7  [6] = polarity, [5:0] = edge position P (0..62; 63 = no-edge)
- sweep_len  in  7  number of codes in a sweep; 0 is treated as 1
- busy  out  1  high from accepted start until the last code is issued
- code_valid  out  1  one-cycle qualifier per output code
- code_out  out  63  generated delay-line word
- value_out  out  7  expected encoder result paired with code_out
- done  out  1  one-cycle pulse together with the last code_valid

Behaviour:
- Reset (async assert, sync deassert at clk edge): busy=0, code_valid=0, done=0, code_out=0, value_out=0, FSM=IDLE.
- Code mapping, with pol=value[6] and P=value[5:0]:
  - For P<63: d(i) = (i - P) mod 63; W[i] = (d(i) & 1) XOR pol. The single equal-bit pair sits at taps (P-1 mod 63, P).
  - Level 2: additionally invert W at d=2.
  - Level 3: additionally invert W at d=2 and at d=60.
  - P=63: W = {63{pol}} (no edge); level is ignored.
- FSM states:
  - IDLE: start=1 latches mode, level, value_in and sweep_len. It sets busy=1 on the next edge and goes to RUN. A start seen while busy=1 is ignored; there is no queueing.
  - RUN: issues one value per cycle into a 2-stage pipeline.
    - Stage 1 registers the value and level.
    - Stage 2 registers code_out, value_out and code_valid.
  - In single mode, exactly one value is issued, then the FSM goes to DRAIN.
  - In sweep mode, the count is decremented per issued value. The next value is P+1 with the same pol. When P=62, the next value is P=0 with pol inverted (ring wrap). A start value with P=63 issues once and then continues at P=0 with pol inverted.
  - DRAIN: waits until the pipeline is empty. busy falls in the same cycle as the last code_valid/done, then the FSM returns to IDLE.
- Latency: start accepted at cycle t gives the first code_valid at t+3 (1 cycle to latch, then PIPE=2). Sweep codes are then on consecutive cycles, with no gaps.
- code_out and value_out hold their last values when code_valid=0.
- Reset mid-sweep aborts immediately: all outputs go to their reset values and no done pulse is produced.
- Simultaneous start and last code in the same cycle: busy is still 1, so the start is ignored.
- level is sampled once at start and held for the whole sweep.

Decomposition:
- Package toa_pkg holds:
  - constants N_TAPS=63, POS_W=6, NO_EDGE=6'd63
  - LVL_IDEAL=1, LVL_BUB1=2, LVL_BUB2=3
  - the FSM state enum {IDLE, RUN, DRAIN}
- Sub-module toa_fine_code_map is purely combinational: (value[6:0], level[2:0]) -> word[62:0]. It sits in pipeline stage 2 and is reusable by the bench as a reference model.
- The top level holds the FSM, the counter, value increment/wrap and the pipeline registers.

Test Plan:
- Reset, then single mode with value_in=7'h00 and level=1 -> code_out=63'h2AAA_AAAA_AAAA_AAAA and value_out=7'h00, with code_valid/done 3 cycles after start.
- Single mode with value_in=7'h40 and level=1 -> code_out=63'h5555_5555_5555_5555 and value_out=7'h40.
- Single mode with value_in=7'h00 and level=2 -> code_out=63'h2AAA_AAAA_AAAA_AAAE. Repeat with level=0 -> same result as level=1.
- Single mode with value_in=7'h3F, level=3 -> code_out=0. Single mode with value_in=7'h7F, level=3 -> code_out=all ones. value_out equals value_in in both cases.
- Sweep mode with value_in=7'h3E and sweep_len=3 -> value_out sequence 7'h3E, 7'h40, 7'h41 on 3 consecutive cycles. done is asserted with 7'h41, and a start pulsed mid-sweep is ignored.
- Sweep mode with sweep_len=126 and level=1, with rst asserted at the 50th code_valid -> all outputs are 0 asynchronously, there is no done, and a new start after reset works normally.
